proc_ctrl: RTL

Control unit for the 16-bit simple processor. Accepts one instruction word from `DIN` when `Run` is pulsed, steps through T0–T3, and drives the processor datapath. The datapath consists of R0–R7, A, G, the ALU and the shared 16-bit bus mux. It emits all register enables, bus-source selects and ALU op, and pulses `Done` on the final step of every instruction. It sits inside the processor beside the register file and clocks on the processor clock. Instruction memory runs on its own clock outside this block.

---
 rtl/proc_ctrl_if.sv | 31 +++
 rtl/proc_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_if.sv
// Control-side signal bundle of the simple processor: instruction input,
// datapath enables, bus-source selects, ALU op and status.
interface proc_ctrl_if #(
    parameter int NREG = 8
);
    logic            Run;
    logic [15:0]     DIN;
    logic            Gnz;
    logic            IRin;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic            Gout;
    logic            DINout;
    logic            Ain;
    logic            Gin;
    logic [1:0]      ALUop;
    logic            Done;
    logic [1:0]      Tstep;

    // Control unit: consumes the instruction stream, drives the datapath.
    modport master (
        input  Run, DIN, Gnz,
        output IRin, Rin, Rout, Gout, DINout, Ain, Gin, ALUop, Done, Tstep
    );

    // Datapath / memory side: supplies the instruction stream, obeys controls.
    modport slave (
        output Run, DIN, Gnz,
        input  IRin, Rin, Rout, Gout, DINout, Ain, Gin, ALUop, Done, Tstep
    );
endinterface

// File: rtl/proc_ctrl.sv
// Control unit for the 16-bit simple processor. Latches a 9-bit instruction
// on Run in T0, then sequences T1..T3 emitting one-hot register enables,
// bus-source selects and the ALU op. Done marks the last step.
module proc_ctrl #(
    parameter int NREG = 8
) (
    input  logic        Pclk,
    input  logic        Resetn,
    proc_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;

    tstep_e     step_q, step_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [2:0] x_field;
    logic [2:0] y_field;

    logic            irin;
    logic [NREG-1:0] rin;
    logic [NREG-1:0] rout;
    logic            gout;
    logic            dinout;
    logic            ain;
    logic            gin;
    logic [1:0]      aluop;
    logic            done;
    logic [1:0]      tstep;

    // The upper DIN bits carry immediates for the datapath, never control.
    logic unused_din_hi;
    assign unused_din_hi = ^bus.DIN[15:9];

    assign opcode  = ir_q[8:6];
    assign x_field = ir_q[5:3];
    assign y_field = ir_q[2:0];

    function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Step counter and instruction register, synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge Pclk) begin
        if (!Resetn) begin
            step_q <= T0;
            ir_q   <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    // Next-step and control decode from (step, IR, Gnz); reset forces all low.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        irin   = 1'b0;
        rin    = '0;
        rout   = '0;
        gout   = 1'b0;
        dinout = 1'b0;
        ain    = 1'b0;
        gin    = 1'b0;
        aluop  = 2'b00;
        done   = 1'b0;
        tstep  = step_q;

        unique case (step_q)
            T0: begin
                irin = bus.Run;
                if (bus.Run) begin
                    ir_d   = bus.DIN[8:0];
                    step_d = T1;
                end
            end
            T1: begin
                unique case (opcode)
                    OP_MV: begin
                        rout = onehot(y_field);
                        rin  = onehot(x_field);
                        done = 1'b1;
                    end
                    OP_MVI: begin
                        dinout = 1'b1;
                        rin    = onehot(x_field);
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        rout = onehot(x_field);
                        ain  = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (bus.Gnz) begin
                            rout = onehot(y_field);
                            rin  = onehot(x_field);
                        end
                        done = 1'b1;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
                step_d = done ? T0 : T2;
            end
            T2: begin
                rout = onehot(y_field);
                gin  = 1'b1;
                unique case (opcode)
                    OP_SUB:  aluop = 2'b01;
                    OP_AND:  aluop = 2'b10;
                    default: aluop = 2'b00;
                endcase
                step_d = T3;
            end
            T3: begin
                gout   = 1'b1;
                rin    = onehot(x_field);
                done   = 1'b1;
                step_d = T0;
            end
            default: step_d = T0;
        endcase

        // Outputs stay quiet for the whole reset cycle, aborting any instruction.
        if (!Resetn) begin
            irin   = 1'b0;
            rin    = '0;
            rout   = '0;
            gout   = 1'b0;
            dinout = 1'b0;
            ain    = 1'b0;
            gin    = 1'b0;
            aluop  = 2'b00;
            done   = 1'b0;
            tstep  = T0;
        end
    end

    assign bus.IRin   = irin;
    assign bus.Rin    = rin;
    assign bus.Rout   = rout;
    assign bus.Gout   = gout;
    assign bus.DINout = dinout;
    assign bus.Ain    = ain;
    assign bus.Gin    = gin;
    assign bus.ALUop  = aluop;
    assign bus.Done   = done;
    assign bus.Tstep  = tstep;

endmodule
